// File: rtl/gam_input_sequencer_if.sv
`default_nettype none
// ============================================================================
// gam_input_sequencer_if : host sample bus + controller presentation bus
// Rev 1.0
// ============================================================================
package gam_input_sequencer_pkg;
  typedef enum logic {
    WAIT  = 1'b0,
    READY = 1'b1
  } READY_WAIT_T;
endpackage

interface gam_input_sequencer_if #(
  parameter int X_W = 16,
  parameter int C_W = 4
);
  import gam_input_sequencer_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [X_W-1:0]  in_x;
  logic [C_W-1:0]  in_c;
  READY_WAIT_T     ready_wait;
  logic            learning_done;
  logic [X_W-1:0]  x_out;
  logic [C_W-1:0]  c_out;

  modport master (
    output in_valid, in_x, in_c, ready_wait,
    input  in_ready, learning_done, x_out, c_out
  );

  modport slave (
    input  in_valid, in_x, in_c, ready_wait,
    output in_ready, learning_done, x_out, c_out
  );
endinterface
`default_nettype wire

// File: rtl/gam_input_sequencer.sv
`default_nettype none
// ============================================================================
// gam_input_sequencer : FIFO-buffered sample feeder for the GAM memory layer
// Rev 1.0
// ============================================================================
module gam_input_sequencer #(
  parameter int X_W   = 16,
  parameter int C_W   = 4,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  wire              clk,
  input  wire              reset,
  input  wire              start,
  input  wire              abort,
  input  wire [CNT_W-1:0]  num_samples,
  gam_input_sequencer_if.slave bus,
  output logic [CNT_W-1:0] remaining,
  output logic             busy,
  output logic             protocol_err
);
  import gam_input_sequencer_pkg::*;

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state, w_next_state;
  logic [X_W-1:0]   r_mem_x [DEPTH];
  logic [C_W-1:0]   r_mem_c [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [AW:0]      r_count;
  logic [X_W-1:0]   r_x_out;
  logic [C_W-1:0]   r_c_out;
  logic [CNT_W-1:0] r_remaining;
  logic             r_err;

  logic w_full, w_ready, w_push, w_pop, w_start_ok;

  assign w_full     = (r_count == C_FULL);
  assign w_ready    = (bus.ready_wait == READY);
  // abort flushes the FIFO, so it also suppresses any push/pop in its cycle
  assign w_push     = bus.in_valid && !w_full && !abort;
  assign w_pop      = (r_state == S_RUN) && w_ready && (r_count != '0) &&
                      (r_remaining != '0) && !abort;
  assign w_start_ok = start && !abort && (r_state != S_RUN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (abort) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: if (start) w_next_state = (num_samples != '0) ? S_RUN : S_DONE;
        S_RUN:          if (w_pop && r_remaining == CNT_W'(1)) w_next_state = S_DONE;
        default:        w_next_state = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy              = (r_state == S_RUN);
    bus.learning_done = !((r_state == S_RUN) && (r_count != '0) && (r_remaining != '0));
    bus.in_ready      = !w_full;
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_x[r_wr_ptr] <= bus.in_x;
      r_mem_c[r_wr_ptr] <= bus.in_c;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_x_out     <= '0;
      r_c_out     <= '0;
      r_remaining <= '0;
      r_err       <= 1'b0;
    end else if (abort) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_remaining <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) begin
        r_rd_ptr    <= r_rd_ptr + AW'(1);
        r_x_out     <= r_mem_x[r_rd_ptr];
        r_c_out     <= r_mem_c[r_rd_ptr];
        r_remaining <= r_remaining - CNT_W'(1);
      end else if (w_start_ok) begin
        r_remaining <= num_samples;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_ready && !w_pop) r_err <= 1'b1;
    end
  end

  assign bus.x_out    = r_x_out;
  assign bus.c_out    = r_c_out;
  assign remaining    = r_remaining;
  assign protocol_err = r_err;

endmodule
`default_nettype wire

// File: doc/gam_input_sequencer.md
# gam_input_sequencer

Upstream feeder for the GAM memory-layer controller. It buffers host training samples (feature vector X, class label C) in a small FIFO. It meters them into the memory layer one at a time using the controller's `ready_wait` handshake. It drives the controller's `learning_done` input so the controller only leaves idle when a sample is actually available, and parks it once the session's sample budget is spent.

## Interface
Parameters:
- `X_W`, 16, feature vector width
- `C_W`, 4, class label width
- `DEPTH`, 4, FIFO entries (power of two, ≥2)
- `CNT_W`, 16, session sample counter width

Ports:
- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  pulse; begins a learning session
- `abort`  in  1  pulse; ends session and flushes FIFO
- `num_samples`  in  CNT_W  samples to present; latched on accepted `start`
- `in_valid`  in  1  host sample valid
- `in_ready`  out  1  FIFO can accept
- `in_x`  in  X_W  host feature vector
- `in_c`  in  C_W  host class label
- `ready_wait`  in  READY_WAIT_T  controller handshake (READY/WAIT)
- `learning_done`  out  1  to controller; 1 holds it in idle
- `x_out`  out  X_W  presented feature vector
- `c_out`  out  C_W  presented class label
- `remaining`  out  CNT_W  samples still to present this session
- `busy`  out  1  session in progress
- `protocol_err`  out  1  sticky; READY seen with nothing to present

## Operation
- FSM states: S_IDLE, S_RUN, S_DONE.
  - S_IDLE → S_RUN on `start` when `num_samples`≠0. `remaining`←`num_samples`.
  - S_IDLE → S_DONE on `start` when `num_samples`=0.
  - S_RUN → S_DONE on the pop that takes `remaining` to 0.
  - S_DONE → S_RUN/S_DONE on `start`, with the same rule as S_IDLE.
  - `start` is ignored in S_RUN.
  - `abort` in any state → S_IDLE. It flushes the FIFO (count←0) and clears `protocol_err`. `abort` has priority over `start`.
- FIFO:
  - `in_ready` = !full in every state.
  - A push occurs when `in_valid`&&`in_ready`.
  - Entries persist across sessions; they are cleared only by `abort` or `reset`.
- Pop/present:
  - A pop occurs in S_RUN when `ready_wait`==READY and the FIFO is non-empty.
  - On a pop, `x_out`/`c_out` are loaded from the FIFO head, the head pointer advances, and `remaining` decrements.
  - `x_out`/`c_out` hold until the next pop. This covers the controller's later write states.
- `learning_done` = !(state==S_RUN && count≠0 && `remaining`≠0). It is combinational from registers only, with no input-to-output path.
- `busy` = (state==S_RUN).
- READY with the FIFO empty, or READY outside S_RUN:
  - sets `protocol_err`;
  - does not change `x_out`, `c_out`, `remaining` or the FIFO.
- Push and pop in the same cycle: count is unchanged and both take effect. Push into a full FIFO is impossible because `in_ready`=0; a pop in that cycle frees the slot for the next cycle.
- Pointers wrap modulo DEPTH. Count ranges 0..DEPTH.

## Timing
- Reset (asynchronous assert, synchronous release) values:
  - FSM S_IDLE, count 0
  - `x_out`=0, `c_out`=0, `remaining`=0
  - `busy`=0, `protocol_err`=0, `learning_done`=1, `in_ready`=1
- Reset asserted mid-session discards everything, including buffered samples.
- Push accepted at edge k → count≥1 after k → `learning_done` falls after edge k (when in S_RUN with `remaining`≠0).
- Controller sees `learning_done`=0 in idle → READY during the next cycle → pop at the end of that READY cycle. New `x_out`/`c_out` are valid in the cycle after READY, which is the controller's new_input cycle.
- Pop of the last budgeted sample: S_DONE, `learning_done`=1 and `busy`=0 one cycle after the READY cycle.
- FIFO emptied by a pop: `learning_done` rises the next cycle. The controller is mid-sample then and re-checks only on return to idle.
- `start` to `busy`: 1 cycle.
- Throughput: at most one sample per controller pass, minimum 3 cycles (idle→ready→new_input).

## Test plan
- Reset: drive `reset`=0 mid-run with 2 entries buffered → all outputs at their reset values immediately; after release, count 0 and `learning_done`=1.
- Basic session: DEPTH=4, push (0x0011,1), (0x0022,2), (0x0033,3), `start` with `num_samples`=3, and a behavioural controller model issuing READY → `x_out`/`c_out` equal each pair in order, each appearing the cycle after its READY; `remaining` goes 3→2→1→0; S_DONE and `learning_done`=1 after the third pop.
- Starvation: `num_samples`=2, FIFO empty at `start` → `learning_done` stays 1 until the first push; it returns to 1 after the pop that empties the FIFO, with `remaining`=1.
- Full/simultaneous: push 4 entries with no READY → `in_ready`=0. Then READY plus `in_valid` in the same cycle → pop occurs, push is blocked that cycle, and `in_ready`=1 the next cycle with count 3.
- Zero budget: `start` with `num_samples`=0 → S_DONE next cycle, `learning_done` never falls, `busy` stays 0.
- Errors: READY with the FIFO empty in S_RUN → `protocol_err`=1, `x_out`/`remaining` unchanged. Then `abort` → S_IDLE, FIFO flushed, `protocol_err`=0.
